// File: rtl/rsp_fifo_pkg.sv
// rsp_fifo_pkg: shared constants for the response FIFOs that sit after the
// MMU tree response arbiters.
//   FIFO_PTR_WIDTH : default address width of a response FIFO (DEPTH = 2**w).
//   RSP_AF_MARGIN  : free-slot margin at which almost_full asserts. It must be
//                    at least the number of responses that can still be in
//                    flight in the tree pipeline once the dispatcher stalls.
package rsp_fifo_pkg;

  localparam int FIFO_PTR_WIDTH = 4;
  localparam int RSP_AF_MARGIN  = 4;

endpackage

// File: rtl/rsp_fifo_mem.sv
// rsp_fifo_mem: DEPTH x DATA_WIDTH storage for rsp_fifo. It has a synchronous
// write port and an asynchronous read port. The array has no reset, so it can
// later be swapped for a RAM macro without touching the control logic.
//   clk     : write clock, rising edge
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data (combinational from raddr_i)
module rsp_fifo_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int PTR_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [PTR_WIDTH-1:0]  waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [PTR_WIDTH-1:0]  raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = 2 ** PTR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rsp_fifo.sv
// rsp_fifo: first-word-fall-through response buffer that sits between the
// tree response arbiters and the host-side reader.
//   clk, rst_n  : clock (rising edge) and asynchronous active-low reset
//   wr_en       : write strobe, no ready (a write while full is dropped)
//   wr_data     : packed response
//   almost_full : occupancy >= DEPTH - AF_MARGIN (decoded from flops only)
//   full        : all DEPTH entries occupied
//   rd_valid    : head entry present
//   rd_ready    : reader accepts the head entry
//   rd_data     : head entry, forced to 0 while rd_valid = 0
//   data_count  : current occupancy 0..DEPTH
//   peak_count  : maximum occupancy since reset or stat_clr
//   overflow    : sticky flag, set when a write is dropped
//   stat_clr    : synchronous clear of overflow and peak_count
// Read handshake: an entry moves to the reader on a rising edge where
// rd_valid and rd_ready are both 1. rd_ready has no effect while rd_valid = 0,
// and rd_valid does not depend on rd_ready.
module rsp_fifo
  import rsp_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int PTR_WIDTH  = FIFO_PTR_WIDTH,
  parameter int AF_MARGIN  = RSP_AF_MARGIN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  almost_full,
  output logic                  full,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [PTR_WIDTH:0]    data_count,
  output logic [PTR_WIDTH:0]    peak_count,
  output logic                  overflow,
  input  logic                  stat_clr
);

  localparam int               DEPTH    = 2 ** PTR_WIDTH;
  localparam logic [PTR_WIDTH:0] AF_LEVEL = (PTR_WIDTH + 1)'(DEPTH - AF_MARGIN);
  localparam logic [PTR_WIDTH:0] PTR_ONE  = {{PTR_WIDTH{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit, so full and empty can be told apart
  // when the low bits match.
  logic [PTR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_WIDTH:0] peak_q, peak_d;
  logic               overflow_q, overflow_d;

  logic               empty;
  logic               full_w;
  logic               pop;
  logic               push;
  logic               drop;
  logic [PTR_WIDTH:0] count_d;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full_w = (wr_ptr_q[PTR_WIDTH-1:0] == rd_ptr_q[PTR_WIDTH-1:0]) &&
                  (wr_ptr_q[PTR_WIDTH] != rd_ptr_q[PTR_WIDTH]);

  // A pop in the same cycle frees the slot, so a write to a full FIFO is
  // still accepted.
  assign pop  = !empty && rd_ready;
  assign push = wr_en && (!full_w || pop);
  assign drop = wr_en && full_w && !pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    peak_d     = peak_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;

    count_d = wr_ptr_d - rd_ptr_d;

    // If a drop and a clear happen in the same cycle, the drop sets the flag.
    if (stat_clr) overflow_d = 1'b0;
    if (drop)     overflow_d = 1'b1;

    if (stat_clr)              peak_d = count_d;
    else if (count_d > peak_q) peak_d = count_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      peak_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      peak_q     <= peak_d;
      overflow_q <= overflow_d;
    end
  end

  rsp_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .PTR_WIDTH  (PTR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q[PTR_WIDTH-1:0]),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q[PTR_WIDTH-1:0]),
    .rdata_o (mem_rdata)
  );

  // All flags below come from pointer flops only, so no input reaches them
  // combinationally.
  assign data_count  = wr_ptr_q - rd_ptr_q;
  assign full        = full_w;
  assign almost_full = (data_count >= AF_LEVEL);
  assign rd_valid    = !empty;
  assign rd_data     = rd_valid ? mem_rdata : '0;
  assign peak_count  = peak_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_rsp_fifo.sv
// tb_rsp_fifo: self-checking bench for rsp_fifo (DEPTH 16, AF_MARGIN 4, 8-bit).
// The reference is a queue of entries plus plain-integer status values.
module tb_rsp_fifo;

  localparam int DW    = 8;
  localparam int PW    = 4;
  localparam int DEPTH = 16;
  localparam int AFM   = 4;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_ready = 1'b0;
  logic          stat_clr = 1'b0;
  logic          almost_full, full, rd_valid, overflow;
  logic [DW-1:0] rd_data;
  logic [PW:0]   data_count, peak_count;

  always #5 clk = ~clk;

  rsp_fifo #(
    .DATA_WIDTH (DW),
    .PTR_WIDTH  (PW),
    .AF_MARGIN  (AFM)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .almost_full (almost_full),
    .full        (full),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .data_count  (data_count),
    .peak_count  (peak_count),
    .overflow    (overflow),
    .stat_clr    (stat_clr)
  );

  // ---------------- scoreboard / reference model ----------------
  logic [DW-1:0] exp_q[$];
  int            peak_m;
  bit            ovf_m;
  int            n_cmp;
  int            n_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    peak_m = 0;
    ovf_m  = 1'b0;
  endtask

  task automatic check_all(input string ph);
    int n;
    n = exp_q.size();
    check({ph, ".rd_valid"},    32'(rd_valid),    32'(n > 0));
    check({ph, ".rd_data"},     32'(rd_data),     (n > 0) ? 32'(exp_q[0]) : 32'd0);
    check({ph, ".data_count"},  32'(data_count),  32'(n));
    check({ph, ".full"},        32'(full),        32'(n == DEPTH));
    check({ph, ".almost_full"}, 32'(almost_full), 32'(n >= DEPTH - AFM));
    check({ph, ".peak_count"},  32'(peak_count),  32'(peak_m));
    check({ph, ".overflow"},    32'(overflow),    32'(ovf_m));
  endtask

  // ---------------- driver ----------------
  // Called just after a falling edge. It drives the inputs, works out from the
  // reference what the next rising edge should do, then checks at the
  // following falling edge.
  task automatic cycle(input string ph, input bit we, input logic [DW-1:0] d,
                       input bit rr, input bit clr);
    bit do_pop, do_push, do_drop, was_full;
    wr_en    = we;
    wr_data  = d;
    rd_ready = rr;
    stat_clr = clr;
    was_full = (exp_q.size() == DEPTH);
    do_pop   = (exp_q.size() > 0) && rr;
    do_push  = we && (!was_full || do_pop);
    do_drop  = we && was_full && !do_pop;
    @(posedge clk);
    if (do_pop)  void'(exp_q.pop_front());
    if (do_push) exp_q.push_back(d);
    ovf_m  = do_drop ? 1'b1 : (clr ? 1'b0 : ovf_m);
    peak_m = clr ? exp_q.size() : ((exp_q.size() > peak_m) ? exp_q.size() : peak_m);
    @(negedge clk);
    wr_en    = 1'b0;
    rd_ready = 1'b0;
    stat_clr = 1'b0;
    check_all(ph);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_cmp = 0;
    n_err = 0;
    model_reset();

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_all("idle");

    // Single write appears at the head one edge later.
    cycle("wr_a5", 1'b1, 8'hA5, 1'b0, 1'b0);
    check("wr_a5.head", 32'(rd_data), 32'h0000_00A5);
    cycle("pop_a5", 1'b0, 8'h00, 1'b1, 1'b0);

    // Fill: almost_full on the 12th write, full at 16.
    for (int i = 0; i < 16; i++) begin
      cycle("fill", 1'b1, DW'(i), 1'b0, 1'b0);
      if (i == 10) check("fill.af_before_12", 32'(almost_full), 32'd0);
      if (i == 11) check("fill.af_at_12",     32'(almost_full), 32'd1);
    end
    check("fill.full", 32'(full), 32'd1);
    check("fill.peak", 32'(peak_count), 32'd16);

    // Write dropped while full, then clear the statistics.
    cycle("drop", 1'b1, 8'hEE, 1'b0, 1'b0);
    check("drop.overflow", 32'(overflow),   32'd1);
    check("drop.count",    32'(data_count), 32'd16);
    check("drop.head",     32'(rd_data),    32'd0);
    cycle("clr", 1'b0, 8'h00, 1'b0, 1'b1);
    check("clr.overflow", 32'(overflow),   32'd0);
    check("clr.peak",     32'(peak_count), 32'd16);

    // Push and pop together while full, across pointer wrap.
    for (int i = 0; i < 20; i++) cycle("full_rw", 1'b1, DW'($urandom), 1'b1, 1'b0);
    check("full_rw.overflow", 32'(overflow), 32'd0);
    check("full_rw.full",     32'(full),     32'd1);

    // Drain, then write into an empty FIFO with rd_ready already high.
    for (int i = 0; i < DEPTH; i++) cycle("drain", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("empty_rw", 1'b1, 8'h3C, 1'b1, 1'b0);
    check("empty_rw.count", 32'(data_count), 32'd1);
    check("empty_rw.head",  32'(rd_data),    32'h3C);
    cycle("empty_rw_pop", 1'b0, 8'h00, 1'b1, 1'b0);
    check("empty_rw_pop.count", 32'(data_count), 32'd0);

    // Asynchronous reset with 7 entries held.
    for (int i = 0; i < 7; i++) cycle("pre_rst", 1'b1, DW'($urandom), 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    check_all("in_rst");
    rst_n = 1'b1;
    cycle("post_rst", 1'b1, 8'h5A, 1'b0, 1'b0);
    check("post_rst.head", 32'(rd_data), 32'h5A);
    cycle("post_rst_pop", 1'b0, 8'h00, 1'b1, 1'b0);

    // Random traffic in phases, each with its own write/read bias so that the
    // FIFO is driven both to full and to empty.
    for (int ph = 0; ph < 8; ph++) begin
      int wp, rp;
      wp = (ph % 2 == 0) ? 85 : 35;
      rp = (ph % 2 == 0) ? 30 : 80;
      for (int i = 0; i < 60; i++) begin
        cycle("rand",
              ($urandom_range(99) < wp),
              DW'($urandom),
              ($urandom_range(99) < rp),
              ($urandom_range(29) == 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard stop in case the stimulus process stalls.
  initial begin
    #200000;
    n_err++;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rsp_fifo.md
# rsp_fifo

Response buffer downstream of the MMU tree: one instance captures alloc responses and a second captures free responses, after the response arbiters, and holds them for the host-side reader. Each instance is a synchronous first-word-fall-through FIFO. It provides an almost-full flag that back-pressures the dispatcher early enough to absorb responses already in flight in the tree pipeline. It also provides a sticky overflow flag and a peak-occupancy monitor for debug.

## Interface
Parameters:
- DATA_WIDTH, default 32: packed response width; the instantiating level concatenates the response fields.
- PTR_WIDTH, default `FIFO_PTR_WIDTH: address width; DEPTH = 2**PTR_WIDTH.
- AF_MARGIN, default 4: free-slot margin at which almost_full asserts; must cover the tree's in-flight responses.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write strobe from the arbiter; no ready handshake.
- wr_data  in  DATA_WIDTH  packed response.
- almost_full  out  1  drives alloc_rsp_fifo_almost_full / free_rsp_fifo_almost_full.
- full  out  1  all DEPTH entries occupied.
- rd_valid  out  1  head entry present (not empty).
- rd_ready  in  1  reader accepts the head entry.
- rd_data  out  DATA_WIDTH  head entry; forced to 0 while rd_valid=0.
- data_count  out  PTR_WIDTH+1  current occupancy, 0..DEPTH.
- peak_count  out  PTR_WIDTH+1  maximum occupancy since reset or clear.
- overflow  out  1  sticky: set when a write was dropped.
- stat_clr  in  1  synchronous clear of overflow and peak_count.

## Operation
- Write and read pointers are PTR_WIDTH+1 bits wide; the MSB is the wrap bit.
- empty = pointers equal. full = low bits equal and MSBs differ.
- data_count = wr_ptr - rd_ptr, computed modulo 2**(PTR_WIDTH+1).
- Push: accepted when wr_en=1 and either (not full) or (full and pop this cycle). On accept, mem[wr_ptr low bits] <= wr_data and wr_ptr increments.
- Push dropped when wr_en=1, full=1 and no pop this cycle. The data is lost, overflow <= 1 and pointers are unchanged.
- Pop: occurs when rd_valid=1 and rd_ready=1; rd_ptr increments. rd_ready while empty is ignored.
- Simultaneous push and pop: both take effect. This holds when full. When empty, the pop cannot occur because rd_valid=0, so only the push is accepted.
- almost_full = (data_count >= DEPTH - AF_MARGIN). It is decoded from flops only, with no input-to-output combinational path.
- peak_count: each cycle it is updated to max(peak_count, next data_count).
- stat_clr: overflow <= 0 and peak_count <= the next data_count. If an overflow occurs in the same cycle, overflow is still set; set wins over clear.
- The storage array is not reset. Pointers and status registers are reset.

## Timing
- Reset values: rd_valid=0, rd_data=0, full=0, almost_full=0 (requires AF_MARGIN < DEPTH), data_count=0, peak_count=0, overflow=0.
- Reset asserted mid-operation discards all contents immediately, asynchronously.
- Write-to-read latency: a write at edge N gives rd_valid=1 with that data after edge N. The data is available to the reader in cycle N+1.
- rd_data is combinational from mem[rd_ptr] gated by rd_valid. It changes only after a pop edge or a first write.
- data_count, full, almost_full and rd_valid all update on the same edge as the pointer change.
- Wrap-around: pointers roll from 2*DEPTH-1 to 0 with no bubble.

## Structure
- `FIFO_PTR_WIDTH, `REQ_ID_WIDTH, `ALL_PAGE_IDX_WIDTH, `FAIL_REASON_WIDTH and `REQ_SIZE_TYPE_WIDTH stay in the shared defines file.
- A shared RSP_AF_MARGIN constant is added to the shared defines file, sized to the tree pipeline depth.
- The alloc and free instance DATA_WIDTH values are derived from those defines at the instantiating level.
- One sub-module, rsp_fifo_mem: a DEPTH x DATA_WIDTH array with a synchronous write port and an asynchronous read port, isolating storage for later RAM-macro substitution.
- Pointer, flag and statistics logic stays in rsp_fifo.

## Test plan
Bench configuration for all scenarios: PTR_WIDTH=4 (DEPTH 16), AF_MARGIN=4, DATA_WIDTH=8.
- Reset, then one write of 0xA5: rd_valid=1 and rd_data=0xA5 in the next cycle, data_count=1. Before the write: rd_data=0, all flags 0.
- Write 0x00..0x0B with rd_ready=0: almost_full rises exactly on the 12th write edge and data_count=12. Continue to 16: full=1, peak_count=16.
- While full, write 0xEE with rd_ready=0: overflow=1, data_count stays 16, head unchanged. Then pulse stat_clr: overflow=0, peak_count=16.
- While full, assert wr_en and rd_ready together for 20 cycles: no overflow, full stays 1, and data emerges in write order across pointer wrap.
- Empty FIFO with rd_ready=1 and wr_en=1 on 0x3C: no pop in that cycle, data_count=1, and 0x3C pops on the following edge.
- Assert rst_n=0 asynchronously with 7 entries held: all outputs return to reset values before the next clock edge. After release, the first write is read back correctly.
